sub_serial: RTL

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, one bit per cycle, LSB first.
// Define SUB_SERIAL_OVF_EN to add the signed overflow output ovf.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_acc;
  logic             r_br;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_br_next;
  logic [WIDTH-1:0] w_shift;

  assign w_accept  = start & (r_state != SHIFT);
  assign w_last    = (r_state == SHIFT) & (r_cnt == LAST);
  assign w_bit     = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0])
                   | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_shift   = {w_bit, r_acc};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_br   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_acc <= w_shift[WIDTH-1:1];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_d    <= w_shift;
        r_bout <= w_br_next;
      end
    end
  end

  assign d    = r_d;
  assign bout = r_bout;

`ifdef SUB_SERIAL_OVF_EN
  logic r_ovf;

  // On the last bit r_a[0]/r_b[0] hold the operand MSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && w_last) begin
      r_ovf <= (r_a[0] != r_b[0]) & (w_bit != r_a[0]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
